fb_responder: RTL
=================

FB_RESPONDER -- requirements
Module: fb_responder

Interface
REQ-001 Parameter READ_LATENCY, default 2, cycles from ram_address presented to ram_rd_data valid (legal 1..4).
REQ-002 Parameter STARVE_LIMIT, default 8, consecutive VGA grants allowed while a CPU request waits (used only with FB_FAIR_ARB_EN).
REQ-003 sys_clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 fb_address  in  16  VGA prefetch word address.
REQ-006 fb_access  in  1  VGA read request, held until fb_ack.
REQ-007 fb_ack  out  1  one-cycle VGA read completion.
REQ-008 fb_data  out  16  VGA read data, valid only while fb_ack=1.
REQ-009 cpu_address  in  16  CPU word address.
REQ-010 cpu_access  in  1  CPU request, held until cpu_ack.
REQ-011 cpu_wr_en  in  1  1=write, 0=read; sampled with the request.
REQ-012 cpu_bytesel  in  2  byte enables for writes.
REQ-013 cpu_wr_data  in  16  write data.
REQ-014 cpu_ack  out  1  one-cycle CPU completion.
REQ-015 cpu_data  out  16  CPU read data, valid only while cpu_ack=1; 0 on write acks.
REQ-016 ram_address  out  16, ram_wr_en  out  1, ram_bytesel  out  2, ram_wr_data  out  16, ram_rd_data  in  16: single-port video RAM.

Function
REQ-017 States: IDLE, READ_WAIT, WRITE, ACK; all outputs registered.
REQ-018 In IDLE, a pending request is accepted on the clock edge; address, wr_en, bytesel and wr_data are latched on that edge; requester inputs are ignored outside IDLE.
REQ-019 Default priority: VGA over CPU when both are pending in the same IDLE cycle.
REQ-020 Read: ram_address drives the latched address from the cycle after acceptance; READ_WAIT lasts READ_LATENCY cycles; data captured into fb_data/cpu_data; ack asserted READ_LATENCY+1 cycles after the acceptance cycle (READ_LATENCY=2: accept cycle 0, ack cycle 3).
REQ-021 Write: ram_wr_en=1 for exactly one cycle (cycle after acceptance) with latched address, bytesel, data; cpu_ack asserted the following cycle.
REQ-022 ACK state lasts one cycle, then IDLE; no request is accepted in the ACK cycle, so the earliest back-to-back acceptance is the cycle after ack.
REQ-023 ram_wr_en is 0 in every state except WRITE; ram_address holds its last value when idle.
REQ-024 Data outputs are 0 whenever their ack is 0.
REQ-025 fb_ack and cpu_ack are never asserted in the same cycle.
REQ-026 A requester dropping access before ack is illegal; behaviour then is undefined but the FSM still completes and returns to IDLE.

Reset
REQ-027 Reset forces IDLE; fb_ack, cpu_ack, ram_wr_en=0; fb_data, cpu_data, ram_address, ram_bytesel, ram_wr_data=0; starvation counter=0.
REQ-028 Reset asserted mid-transaction aborts it with no ack issued and no RAM write after the reset edge.

Configuration
REQ-029 Macro FB_FAIR_ARB_EN: when defined, a counter increments on each VGA grant while cpu_access=1 and clears on any CPU grant or when cpu_access=0; at STARVE_LIMIT the next IDLE grant goes to the CPU even if fb_access=1.
REQ-030 Without FB_FAIR_ARB_EN, strict VGA priority, no counter logic present.

Verification
REQ-031 RAM[0x0100]=0xBEEF; fb_access with fb_address=0x0100 at cycle 0 -> fb_ack and fb_data=0xBEEF in cycle 3, fb_data=0 in cycle 4.
REQ-032 CPU write 0x1234 to 0x0020, bytesel=2'b01, RAM held 0xAAAA -> ram_wr_en one cycle, cpu_ack next cycle; subsequent CPU read returns 0xAA34.
REQ-033 fb_access and cpu_access (read 0x0010) rise in same cycle -> VGA acked first, CPU accepted cycle after fb_ack, acked 4 cycles later.
REQ-034 FB_FAIR_ARB_EN, STARVE_LIMIT=8, fb_access held continuously with cpu_access pending -> exactly 8 fb_acks, then a cpu_ack, then VGA resumes; without the macro no cpu_ack while fb_access stays high.
REQ-035 reset pulsed in READ_WAIT of a CPU write-after-read sequence -> no ack, ram_wr_en stays 0, next request after reset completes normally.

Source files
------------

// File: rtl/fb_responder_if.sv
// Frame-buffer responder bus: VGA prefetch port, CPU port and single-port video RAM port.
// Latency: none, wiring only.
// Backpressure: each requester holds its *_access until the matching one-cycle *_ack.
interface fb_responder_if;
   logic [15:0] fb_address;
   logic        fb_access;
   logic        fb_ack;
   logic [15:0] fb_data;
   logic [15:0] cpu_address;
   logic        cpu_access;
   logic        cpu_wr_en;
   logic [1:0]  cpu_bytesel;
   logic [15:0] cpu_wr_data;
   logic        cpu_ack;
   logic [15:0] cpu_data;
   logic [15:0] ram_address;
   logic        ram_wr_en;
   logic [1:0]  ram_bytesel;
   logic [15:0] ram_wr_data;
   logic [15:0] ram_rd_data;

   // Responder side
   modport slave (
      input  fb_address, fb_access, cpu_address, cpu_access, cpu_wr_en,
             cpu_bytesel, cpu_wr_data, ram_rd_data,
      output fb_ack, fb_data, cpu_ack, cpu_data,
             ram_address, ram_wr_en, ram_bytesel, ram_wr_data
   );

   // Requester / RAM side
   modport master (
      output fb_address, fb_access, cpu_address, cpu_access, cpu_wr_en,
             cpu_bytesel, cpu_wr_data, ram_rd_data,
      input  fb_ack, fb_data, cpu_ack, cpu_data,
             ram_address, ram_wr_en, ram_bytesel, ram_wr_data
   );
endinterface

// File: rtl/fb_responder.sv
// Arbitrates VGA prefetch reads and CPU reads/writes onto one single-port video RAM.
// Latency: read ack READ_LATENCY+1 cycles after acceptance, write ack 2 cycles after acceptance.
// Backpressure: one transaction at a time; requests wait until IDLE, VGA wins ties.
// Optional feature: define FB_FAIR_ARB_EN to force a CPU grant after STARVE_LIMIT VGA grants.
module fb_responder #(
   parameter int READ_LATENCY = 2,
   parameter int STARVE_LIMIT = 8
) (
   input  logic          sys_clk,
   input  logic          reset,
   fb_responder_if.slave bus
);

   typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE, ACK} state_t;

   localparam logic [1:0] WAIT_LAST = 2'(READ_LATENCY - 1);

   // Reject latencies the 2-bit wait counter cannot represent
   if (READ_LATENCY < 1 || READ_LATENCY > 4 || STARVE_LIMIT < 1) begin : g_bad_params
      $error("fb_responder: READ_LATENCY must be 1..4 and STARVE_LIMIT >= 1");
   end

   state_t      r_state, w_state_nxt;
   logic [1:0]  r_wait_cnt, w_wait_cnt_nxt;
   logic        r_is_cpu, w_is_cpu_nxt;
   logic        r_fb_ack, w_fb_ack_nxt;
   logic [15:0] r_fb_data, w_fb_data_nxt;
   logic        r_cpu_ack, w_cpu_ack_nxt;
   logic [15:0] r_cpu_data, w_cpu_data_nxt;
   logic [15:0] r_ram_address, w_ram_address_nxt;
   logic        r_ram_wr_en, w_ram_wr_en_nxt;
   logic [1:0]  r_ram_bytesel, w_ram_bytesel_nxt;
   logic [15:0] r_ram_wr_data, w_ram_wr_data_nxt;

   logic w_idle;
   logic w_starved;
   logic w_grant_vga;
   logic w_grant_cpu;

   assign w_idle      = (r_state == IDLE);
   // A starved CPU takes the slot even when VGA is also asking
   assign w_grant_vga = bus.fb_access && !(bus.cpu_access && w_starved);
   assign w_grant_cpu = bus.cpu_access && !w_grant_vga;

`ifdef FB_FAIR_ARB_EN
   localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

   logic [STARVE_W-1:0] r_starve_cnt, w_starve_cnt_nxt;

   assign w_starved = (r_starve_cnt >= STARVE_W'(STARVE_LIMIT));

   // Count VGA grants taken while the CPU waits; any CPU grant or idle CPU clears it
   always_comb begin
      w_starve_cnt_nxt = r_starve_cnt;
      if (!bus.cpu_access || (w_idle && w_grant_cpu)) begin
         w_starve_cnt_nxt = '0;
      end else if (w_idle && w_grant_vga && !w_starved) begin
         w_starve_cnt_nxt = r_starve_cnt + 1'b1;
      end
   end

   // Starvation counter register
   always_ff @(posedge sys_clk) begin
      if (reset) r_starve_cnt <= '0;
      else       r_starve_cnt <= w_starve_cnt_nxt;
   end
`else
   assign w_starved = 1'b0;
`endif

   // Next state and next registered outputs; data outputs default to 0 so they only carry data with ack
   always_comb begin
      w_state_nxt       = r_state;
      w_wait_cnt_nxt    = '0;
      w_is_cpu_nxt      = r_is_cpu;
      w_fb_ack_nxt      = 1'b0;
      w_fb_data_nxt     = '0;
      w_cpu_ack_nxt     = 1'b0;
      w_cpu_data_nxt    = '0;
      w_ram_address_nxt = r_ram_address;
      w_ram_wr_en_nxt   = 1'b0;
      w_ram_bytesel_nxt = r_ram_bytesel;
      w_ram_wr_data_nxt = r_ram_wr_data;
      case (r_state)
         IDLE: begin
            if (w_grant_vga) begin
               w_is_cpu_nxt      = 1'b0;
               w_ram_address_nxt = bus.fb_address;
               w_state_nxt       = READ_WAIT;
            end else if (w_grant_cpu) begin
               w_is_cpu_nxt      = 1'b1;
               w_ram_address_nxt = bus.cpu_address;
               w_ram_bytesel_nxt = bus.cpu_bytesel;
               w_ram_wr_data_nxt = bus.cpu_wr_data;
               if (bus.cpu_wr_en) begin
                  w_ram_wr_en_nxt = 1'b1;
                  w_state_nxt     = WRITE;
               end else begin
                  w_state_nxt     = READ_WAIT;
               end
            end
         end
         READ_WAIT: begin
            if (r_wait_cnt == WAIT_LAST) begin
               w_state_nxt = ACK;
               if (r_is_cpu) begin
                  w_cpu_ack_nxt  = 1'b1;
                  w_cpu_data_nxt = bus.ram_rd_data;
               end else begin
                  w_fb_ack_nxt   = 1'b1;
                  w_fb_data_nxt  = bus.ram_rd_data;
               end
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + 2'd1;
            end
         end
         WRITE: begin
            w_cpu_ack_nxt = 1'b1;
            w_state_nxt   = ACK;
         end
         ACK: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_wait_cnt    <= '0;
         r_is_cpu      <= 1'b0;
         r_fb_ack      <= 1'b0;
         r_fb_data     <= '0;
         r_cpu_ack     <= 1'b0;
         r_cpu_data    <= '0;
         r_ram_address <= '0;
         r_ram_wr_en   <= 1'b0;
         r_ram_bytesel <= '0;
         r_ram_wr_data <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_wait_cnt    <= w_wait_cnt_nxt;
         r_is_cpu      <= w_is_cpu_nxt;
         r_fb_ack      <= w_fb_ack_nxt;
         r_fb_data     <= w_fb_data_nxt;
         r_cpu_ack     <= w_cpu_ack_nxt;
         r_cpu_data    <= w_cpu_data_nxt;
         r_ram_address <= w_ram_address_nxt;
         r_ram_wr_en   <= w_ram_wr_en_nxt;
         r_ram_bytesel <= w_ram_bytesel_nxt;
         r_ram_wr_data <= w_ram_wr_data_nxt;
      end
   end

   assign bus.fb_ack      = r_fb_ack;
   assign bus.fb_data     = r_fb_data;
   assign bus.cpu_ack     = r_cpu_ack;
   assign bus.cpu_data    = r_cpu_data;
   assign bus.ram_address = r_ram_address;
   assign bus.ram_wr_en   = r_ram_wr_en;
   assign bus.ram_bytesel = r_ram_bytesel;
   assign bus.ram_wr_data = r_ram_wr_data;

endmodule
